arithm_mc: RTL and testbench

Multi-cycle, parametrised arithmetic unit for the pipelined core's execute stage. Add/sub and multiply complete in one cycle; divide and remainder use an iterative radix-2 restoring divider with a signed/unsigned mode. Operands enter and results leave through valid/ready handshakes, so the pipeline stalls on in_ready. A synchronous flush aborts in-flight work on branch mispredict or exception.

---
 rtl/arithm_mc.sv | 175 +++++++++++++++++
 tb/tb_arithm_mc.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/arithm_mc.sv
// arithm_mc: execute-stage arithmetic unit with single-cycle add/sub/mul
// and an iterative radix-2 restoring divider behind valid/ready handshakes.
module arithm_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opsel,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cf,
  output logic             ovf,
  output logic             busy
);

  localparam int MSB = WIDTH - 1;
  localparam int CW  = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, DIV_RUN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             neg_q;
  logic             neg_r;
  logic             want_rem;

  assign busy     = (state == DIV_RUN);
  assign in_ready = (state == IDLE) && (!out_valid || out_ready)
                    && !flush;

  logic             sub;
  logic [WIDTH-1:0] b_inv;
  logic [WIDTH:0]   sum;
  logic             add_ovf;

  assign sub     = opsel[0];
  assign b_inv   = op_b ^ {WIDTH{sub}};
  assign sum     = {1'b0, op_a} + {1'b0, b_inv}
                   + {{WIDTH{1'b0}}, sub};
  // carry into MSB xor carry out
  assign add_ovf = op_a[MSB] ^ b_inv[MSB] ^ sum[MSB] ^ sum[WIDTH];

  logic [2*WIDTH-1:0] ma;
  logic [2*WIDTH-1:0] mb;
  logic [2*WIDTH-1:0] prod;

  assign ma   = is_signed ? {{WIDTH{op_a[MSB]}}, op_a}
                          : {{WIDTH{1'b0}}, op_a};
  assign mb   = is_signed ? {{WIDTH{op_b[MSB]}}, op_b}
                          : {{WIDTH{1'b0}}, op_b};
  assign prod = ma * mb;

  logic             is_div;
  logic             b_zero;
  logic             min_neg1;
  logic             special;
  logic [WIDTH-1:0] special_res;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  assign is_div   = (opsel[2:1] == 2'b10);
  assign b_zero   = (op_b == '0);
  assign min_neg1 = is_signed && (op_a == {1'b1, {MSB{1'b0}}})
                    && (op_b == '1);
  assign special  = b_zero || min_neg1;
  assign special_res = b_zero ? (opsel[0] ? op_a : '1)
                              : (opsel[0] ? '0 : op_a);
  assign abs_a = (is_signed && op_a[MSB]) ? -op_a : op_a;
  assign abs_b = (is_signed && op_b[MSB]) ? -op_b : op_b;

  logic [WIDTH-1:0] fast_res;
  logic             fast_cf;
  logic             fast_ovf;

  always_comb begin
    fast_res = '0;
    fast_cf  = 1'b0;
    fast_ovf = 1'b0;
    unique case (1'b1)
      (opsel[2:1] == 2'b00): begin
        fast_res = sum[MSB:0];
        fast_cf  = sum[WIDTH];
        fast_ovf = add_ovf;
      end
      (opsel == 3'b010): fast_res = prod[MSB:0];
      (opsel == 3'b011): fast_res = prod[2*WIDTH-1:WIDTH];
      is_div:            fast_res = special_res;
      default:           fast_res = '0;
    endcase
  end

  // One restoring step: shift in next dividend bit, subtract if it fits
  logic [WIDTH:0]   rs;
  logic             ge;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] div_res;

  assign rs      = {rem_r, quo[MSB]};
  assign ge      = (rs >= {1'b0, dvs});
  assign diff    = rs[MSB:0] - dvs;
  assign r_next  = ge ? diff : rs[MSB:0];
  assign q_next  = {quo[MSB-1:0], ge};
  assign div_res = want_rem ? (neg_r ? -r_next : r_next)
                            : (neg_q ? -q_next : q_next);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rem_r     <= '0;
      quo       <= '0;
      dvs       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      want_rem  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      cf        <= 1'b0;
      ovf       <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_ready) out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            if (is_div && !special) begin
              state    <= DIV_RUN;
              cnt      <= CW'(WIDTH);
              rem_r    <= '0;
              quo      <= abs_a;
              dvs      <= abs_b;
              neg_q    <= is_signed && (op_a[MSB] ^ op_b[MSB]);
              neg_r    <= is_signed && op_a[MSB];
              want_rem <= opsel[0];
            end else begin
              result    <= fast_res;
              cf        <= fast_cf;
              ovf       <= fast_ovf;
              out_valid <= 1'b1;
            end
          end
        end
        DIV_RUN: begin
          rem_r <= r_next;
          quo   <= q_next;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state     <= IDLE;
            result    <= div_res;
            cf        <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arithm_mc.sv
// tb_arithm_mc: directed vectors with hand-computed results for arithm_mc,
// covering latency, special cases, flush, backpressure and async reset.
module tb_arithm_mc;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   opsel;
  logic         is_signed;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cf;
  logic         ovf;
  logic         busy;

  int n_chk  = 0;
  int n_fail = 0;

  arithm_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opsel     (opsel),
    .is_signed (is_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cf        (cf),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic sg,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    opsel     = op;
    is_signed = sg;
    op_a      = a;
    op_b      = b;
    in_valid  = 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1 with the result on the port
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic sg, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] er,
                        input logic ecf, input logic eovf,
                        input logic is_long);
    drive(op, sg, a, b);
    #1 check({tag, "_rdy"}, 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (is_long) begin
      for (int k = 0; k < W; k++) begin
        check({tag, "_wait"}, 64'({busy, out_valid, in_ready}),
              64'(3'b100));
        @(posedge clk); #1;
      end
    end
    check({tag, "_vld"}, 64'({out_valid, busy}), 64'(2'b10));
    check(tag, 64'(result), 64'(er));
    check({tag, "_cf"}, 64'(cf), 64'(ecf));
    check({tag, "_ovf"}, 64'(ovf), 64'(eovf));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    opsel     = 3'b000;
    is_signed = 1'b0;
    op_a      = '0;
    op_b      = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    check("rst_vld", 64'(out_valid), 64'(0));
    check("rst_res", 64'(result), 64'(0));
    check("rst_flags", 64'({cf, ovf}), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_rdy", 64'(in_ready), 64'(1));

    run_op("add_wrap", 3'b000, 1'b0, 32'hFFFF_FFFF, 32'h1,
           32'h0, 1'b1, 1'b0, 1'b0);
    run_op("sub_min", 3'b001, 1'b0, 32'h8000_0000, 32'h1,
           32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    run_op("add_small", 3'b000, 1'b0, 32'd5, 32'd3,
           32'd8, 1'b0, 1'b0, 1'b0);
    run_op("sub_borrow", 3'b001, 1'b0, 32'd3, 32'd5,
           32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_op("sub_noborrow", 3'b001, 1'b0, 32'd5, 32'd3,
           32'd2, 1'b1, 1'b0, 1'b0);

    run_op("mulh_u", 3'b011, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_op("mulh_s", 3'b011, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'h0, 1'b0, 1'b0, 1'b0);
    run_op("mull_u", 3'b010, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'h1, 1'b0, 1'b0, 1'b0);
    run_op("mull_s", 3'b010, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'h1, 1'b0, 1'b0, 1'b0);

    // flags must clear on a non-add op following one that set them
    run_op("sub_flags", 3'b001, 1'b0, 32'h8000_0000, 32'h1,
           32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    run_op("rsv_110", 3'b110, 1'b0, 32'd5, 32'd3,
           32'h0, 1'b0, 1'b0, 1'b0);
    run_op("rsv_111", 3'b111, 1'b1, 32'd9, 32'd4,
           32'h0, 1'b0, 1'b0, 1'b0);

    run_op("divu_7_2", 3'b100, 1'b0, 32'd7, 32'd2,
           32'd3, 1'b0, 1'b0, 1'b1);
    run_op("remu_7_2", 3'b101, 1'b0, 32'd7, 32'd2,
           32'd1, 1'b0, 1'b0, 1'b1);
    run_op("divs_m7_2", 3'b100, 1'b1, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFD, 1'b0, 1'b0, 1'b1);
    run_op("rems_m7_2", 3'b101, 1'b1, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    run_op("divs_7_m2", 3'b100, 1'b1, 32'd7, 32'hFFFF_FFFE,
           32'hFFFF_FFFD, 1'b0, 1'b0, 1'b1);
    run_op("rems_7_m2", 3'b101, 1'b1, 32'd7, 32'hFFFF_FFFE,
           32'd1, 1'b0, 1'b0, 1'b1);
    run_op("divu_big", 3'b100, 1'b0, 32'hFFFF_FFFF, 32'h10,
           32'h0FFF_FFFF, 1'b0, 1'b0, 1'b1);
    run_op("remu_big", 3'b101, 1'b0, 32'hFFFF_FFFF, 32'h10,
           32'hF, 1'b0, 1'b0, 1'b1);
    run_op("divu_min_m1", 3'b100, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h0, 1'b0, 1'b0, 1'b1);
    run_op("remu_min_m1", 3'b101, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h8000_0000, 1'b0, 1'b0, 1'b1);

    run_op("div_by0", 3'b100, 1'b0, 32'd5, 32'd0,
           32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    run_op("rem_by0", 3'b101, 1'b0, 32'd5, 32'd0,
           32'd5, 1'b0, 1'b0, 1'b0);
    run_op("divs_min_m1", 3'b100, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h8000_0000, 1'b0, 1'b0, 1'b0);
    run_op("rems_min_m1", 3'b101, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h0, 1'b0, 1'b0, 1'b0);

    // Flush on the tenth cycle of a divide, with an add offered alongside
    drive(3'b100, 1'b0, 32'd100, 32'd7);
    #1 check("fl_div_rdy", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("fl_pre_busy", 64'(busy), 64'(1));
    flush = 1'b1;
    drive(3'b000, 1'b0, 32'd2, 32'd3);
    #1 check("fl_rdy_low", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    flush = 1'b0;
    check("fl_busy", 64'(busy), 64'(0));
    check("fl_vld", 64'(out_valid), 64'(0));
    run_op("fl_add", 3'b000, 1'b0, 32'd2, 32'd3,
           32'd5, 1'b0, 1'b0, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    check("fl_no_res", 64'({out_valid, busy}), 64'(0));

    // Backpressure: result must hold and block new ops
    out_ready = 1'b0;
    run_op("bp_add", 3'b000, 1'b0, 32'd10, 32'd20,
           32'd30, 1'b0, 1'b0, 1'b0);
    drive(3'b000, 1'b0, 32'd1, 32'd1);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_rdy", 64'(in_ready), 64'(0));
      check("bp_hold", 64'({out_valid, result}), {31'd0, 1'b1, 32'd30});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1 check("bp_rel_rdy", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_vld", 64'(out_valid), 64'(1));
    check("bp_next", 64'(result), 64'(2));

    // Asynchronous reset in the middle of a divide
    drive(3'b100, 1'b0, 32'd50, 32'd3);
    #1 check("ar_rdy", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("ar_pre_busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    check("ar_busy", 64'(busy), 64'(0));
    check("ar_vld", 64'(out_valid), 64'(0));
    check("ar_res", 64'(result), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("ar_idle", 64'({busy, in_ready}), 64'(2'b01));
    repeat (40) @(posedge clk);
    #1;
    check("ar_no_res", 64'(out_valid), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
